// File: rtl/fwd_hazard_unit_pkg.sv
// fwd_pkg: shared types and constants for the forwarding / hazard unit.
//   fwd_sel_e  : EX operand mux select encodings
//   sb_state_e : multiply scoreboard states
//   REG_ZERO   : hardwired-zero register index, never a hazard source
package fwd_pkg;
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10,
    FWD_MUL   = 2'b11
  } fwd_sel_e;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } sb_state_e;

  localparam int REG_ZERO = 0;
endpackage

// File: rtl/fwd_hazard_unit_mul_scoreboard.sv
// mul_scoreboard: one-entry scoreboard for the multi-cycle multiplier.
// Tracks the outstanding multiply destination and its remaining latency,
// and flags ID operands that must wait on it (mwait) plus a second
// multiply arriving while one is outstanding (strct).
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   id_src_addr/use ID operand addresses and read enables
//   idex_rd/regwrite/mul  instruction currently in EX
//   luse            load-use stall (the only stall source while IDLE)
//   mul_busy        entry outstanding
//   mul_rd          outstanding destination
//   mul_last        final busy cycle (mul_cnt==1)
//   mwait, strct    stall reasons
// Config: FWD_MUL_BYPASS_EN drops mwait on the final busy cycle, since the
// result is bypassed into EX on the following cycle.
module mul_scoreboard
  import fwd_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int MUL_LAT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_use,
  input  logic [REG_AW-1:0]         idex_rd,
  input  logic                      idex_regwrite,
  input  logic                      idex_mul,
  input  logic                      luse,
  output logic                      mul_busy,
  output logic [REG_AW-1:0]         mul_rd,
  output logic                      mul_last,
  output logic                      mwait,
  output logic                      strct
);
  localparam int CW = $clog2(MUL_LAT + 1);

  sb_state_e         state_q, state_d;
  logic [REG_AW-1:0] mul_rd_q, mul_rd_d;
  logic [CW-1:0]     mul_cnt_q, mul_cnt_d;
  logic [NUM_SRC-1:0] hit;

  assign mul_busy = (state_q == MUL_BUSY);
  assign mul_rd   = mul_rd_q;
  assign mul_last = mul_busy && (mul_cnt_q == CW'(1));
  assign strct    = mul_busy && idex_mul;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_hit
`ifdef FWD_MUL_BYPASS_EN
    assign hit[i] = id_src_use[i] && !mul_last
                 && (id_src_addr[i*REG_AW +: REG_AW] == mul_rd_q)
                 && (mul_rd_q != REG_AW'(REG_ZERO));
`else
    assign hit[i] = id_src_use[i]
                 && (id_src_addr[i*REG_AW +: REG_AW] == mul_rd_q)
                 && (mul_rd_q != REG_AW'(REG_ZERO));
`endif
  end

  assign mwait = mul_busy && (|hit);

  always_comb begin
    state_d   = state_q;
    mul_rd_d  = mul_rd_q;
    mul_cnt_d = mul_cnt_q;
    case (state_q)
      IDLE: begin
        // While IDLE mwait/strct are zero, so !luse is exactly !stall.
        if (idex_mul && idex_regwrite && (idex_rd != REG_AW'(REG_ZERO)) && !luse) begin
          state_d   = MUL_BUSY;
          mul_rd_d  = idex_rd;
          mul_cnt_d = CW'(MUL_LAT - 1);
        end
      end
      MUL_BUSY: begin
        if (mul_cnt_q == CW'(1)) begin
          state_d   = IDLE;
          mul_cnt_d = '0;
        end else begin
          mul_cnt_d = mul_cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mul_rd_q  <= '0;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_rd_q  <= mul_rd_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding, load-use and multiply hazard
// detection for the 5-stage pipeline, plus a saturating stall counter.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   id_src_addr/use   ID operands (operand i at [i*REG_AW +: REG_AW])
//   idex_*            instruction in EX (sources, rd, regwrite, load, mul)
//   exmem_*/memwb_*   older writers for forwarding
//   fwd_sel           per-operand select: 00 RF, 10 EX/MEM, 01 MEM/WB, 11 MUL
//   stall/flush_idex  hold PC+IF/ID and bubble ID/EX
//   mul_busy          multiply outstanding
//   stall_cycles      saturating count of stalled cycles
// Config: FWD_MUL_BYPASS_EN enables the 11 multiplier bypass select.
// All combinational outputs are forced low while rst_n is low.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_use,
  input  logic [NUM_SRC*REG_AW-1:0] idex_src_addr,
  input  logic [REG_AW-1:0]         idex_rd,
  input  logic                      idex_regwrite,
  input  logic                      idex_memread,
  input  logic                      idex_mul,
  input  logic [REG_AW-1:0]         exmem_rd,
  input  logic                      exmem_regwrite,
  input  logic [REG_AW-1:0]         memwb_rd,
  input  logic                      memwb_regwrite,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      flush_idex,
  output logic                      mul_busy,
  output logic [CNT_W-1:0]          stall_cycles
);
  localparam logic [REG_AW-1:0] RZ = REG_AW'(REG_ZERO);

  logic sb_busy, mul_last, mwait, strct, luse;
  logic [REG_AW-1:0] mul_rd;
  logic [NUM_SRC-1:0] ld_hit;
  logic [NUM_SRC-1:0][1:0] fwd_raw;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  mul_scoreboard #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MUL_LAT(MUL_LAT)) u_sb (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_src_addr   (id_src_addr),
    .id_src_use    (id_src_use),
    .idex_rd       (idex_rd),
    .idex_regwrite (idex_regwrite),
    .idex_mul      (idex_mul),
    .luse          (luse),
    .mul_busy      (sb_busy),
    .mul_rd        (mul_rd),
    .mul_last      (mul_last),
    .mwait         (mwait),
    .strct         (strct)
  );

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
    logic [REG_AW-1:0] src;
    logic ex_hit, wb_hit, mul_hit;
    assign src    = idex_src_addr[i*REG_AW +: REG_AW];
    assign ex_hit = exmem_regwrite && (exmem_rd != RZ) && (exmem_rd == src);
    assign wb_hit = memwb_regwrite && (memwb_rd != RZ) && (memwb_rd == src);
`ifdef FWD_MUL_BYPASS_EN
    assign mul_hit = mul_last && (mul_rd == src);
`else
    assign mul_hit = 1'b0;
`endif
    assign fwd_raw[i] = mul_hit ? FWD_MUL : ex_hit ? FWD_EXMEM : wb_hit ? FWD_MEMWB : FWD_RF;
    assign fwd_sel[2*i +: 2] = rst_n ? fwd_raw[i] : FWD_RF;
    assign ld_hit[i] = id_src_use[i] && (id_src_addr[i*REG_AW +: REG_AW] == idex_rd);
  end

`ifndef FWD_MUL_BYPASS_EN
  // Bypass info is only consumed when the MUL select is built in.
  logic [REG_AW:0] unused_byp;
  assign unused_byp = {mul_last, mul_rd};
`endif

  assign luse       = idex_memread && idex_regwrite && (idex_rd != RZ) && (|ld_hit);
  // Concurrent stall reasons OR into a single stall cycle.
  assign stall      = rst_n && (luse || mwait || strct);
  assign flush_idex = stall;
  assign mul_busy   = rst_n && sb_busy;
  assign stall_cycles = stall_cycles_q;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench; expected responses are queued by the driver and
// popped/compared by an independent monitor on the falling edge.
module tb_fwd_hazard_unit;
  localparam int REG_AW = 5, NUM_SRC = 2, MUL_LAT = 4, CNT_W = 8;
`ifdef FWD_MUL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [NUM_SRC*REG_AW-1:0] id_src_addr, idex_src_addr;
  logic [NUM_SRC-1:0] id_src_use;
  logic [REG_AW-1:0] idex_rd, exmem_rd, memwb_rd;
  logic idex_regwrite, idex_memread, idex_mul, exmem_regwrite, memwb_regwrite;
  logic [NUM_SRC*2-1:0] fwd_sel;
  logic stall, flush_idex, mul_busy;
  logic [CNT_W-1:0] stall_cycles;

  fwd_hazard_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_src_addr(id_src_addr), .id_src_use(id_src_use),
    .idex_src_addr(idex_src_addr), .idex_rd(idex_rd), .idex_regwrite(idex_regwrite),
    .idex_memread(idex_memread), .idex_mul(idex_mul), .exmem_rd(exmem_rd),
    .exmem_regwrite(exmem_regwrite), .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .fwd_sel(fwd_sel), .stall(stall), .flush_idex(flush_idex), .mul_busy(mul_busy),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    logic [3:0] f;
    bit s;
    bit b;
    logic [CNT_W-1:0] c;
  } exp_t;

  exp_t q[$];
  bit exp_vld = 1'b0;
  int total = 0, bad = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  task automatic cmp(string nm, string fld, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %0h want %0h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_vld) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL queue: got empty want entry");
      end else begin
        e = q.pop_front();
        cmp(e.nm, "fwd_sel", 32'(fwd_sel), 32'(e.f));
        cmp(e.nm, "stall", 32'(stall), 32'(e.s));
        cmp(e.nm, "flush_idex", 32'(flush_idex), 32'(e.s));
        cmp(e.nm, "mul_busy", 32'(mul_busy), 32'(e.b));
        cmp(e.nm, "stall_cycles", 32'(stall_cycles), 32'(e.c));
      end
    end
  end

  // Queue the expectation for the current inputs, then advance one clock.
  task automatic cyc(string nm, logic [3:0] f, bit s, bit b);
    exp_t e;
    e.nm = nm; e.f = f; e.s = s; e.b = b; e.c = exp_cnt;
    q.push_back(e);
    exp_vld = 1'b1;
    @(posedge clk);
    #1 exp_vld = 1'b0;
    if (!rst_n) exp_cnt = '0;
    else if (s && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic clr();
    id_src_addr = '0; id_src_use = '0; idex_src_addr = '0; idex_rd = '0;
    idex_regwrite = 1'b0; idex_memread = 1'b0; idex_mul = 1'b0;
    exmem_rd = '0; exmem_regwrite = 1'b0; memwb_rd = '0; memwb_regwrite = 1'b0;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    @(posedge clk); #1;
    // outputs forced low during reset even with matching inputs
    exmem_rd = 5'd3; exmem_regwrite = 1'b1; idex_src_addr = {5'd0, 5'd3};
    id_src_use = 2'b01; id_src_addr = {5'd0, 5'd5};
    idex_rd = 5'd5; idex_memread = 1'b1; idex_regwrite = 1'b1;
    cyc("rst", 4'b0000, 0, 0);
    rst_n = 1'b1; clr();
    cyc("idle", 4'b0000, 0, 0);

    // forwarding
    exmem_rd = 5'd3; exmem_regwrite = 1'b1; memwb_rd = 5'd3; memwb_regwrite = 1'b1;
    idex_src_addr = {5'd0, 5'd3};
    cyc("fwd_exmem_prio", 4'b0010, 0, 0);
    exmem_rd = 5'd0; memwb_rd = 5'd0; idex_src_addr = {5'd0, 5'd0};
    cyc("fwd_r0", 4'b0000, 0, 0);
    exmem_rd = 5'd3; memwb_rd = 5'd4; idex_src_addr = {5'd4, 5'd3};
    cyc("fwd_both_ops", 4'b0110, 0, 0);
    exmem_regwrite = 1'b0; memwb_rd = 5'd3; idex_src_addr = {5'd3, 5'd3};
    cyc("fwd_memwb", 4'b0101, 0, 0);

    // load-use
    clr(); idex_memread = 1'b1; idex_regwrite = 1'b1; idex_rd = 5'd5;
    id_src_addr = {5'd5, 5'd0}; id_src_use = 2'b10;
    cyc("luse", 4'b0000, 1, 0);
    clr();
    cyc("luse_after", 4'b0000, 0, 0);
    idex_memread = 1'b1; idex_regwrite = 1'b1; idex_rd = 5'd5;
    id_src_addr = {5'd5, 5'd5}; id_src_use = 2'b00;
    cyc("luse_unused", 4'b0000, 0, 0);
    idex_rd = 5'd0; id_src_addr = {5'd0, 5'd0}; id_src_use = 2'b11;
    cyc("luse_r0", 4'b0000, 0, 0);

    // multiply with dependent in ID
    clr(); idex_mul = 1'b1; idex_regwrite = 1'b1; idex_rd = 5'd7;
    id_src_use = 2'b01; id_src_addr = {5'd0, 5'd7};
    cyc("mul_issue", 4'b0000, 0, 0);
    idex_mul = 1'b0; idex_regwrite = 1'b0; idex_rd = 5'd0;
    cyc("mul_wait1", 4'b0000, 1, 1);
    cyc("mul_wait2", 4'b0000, 1, 1);
    idex_src_addr = {5'd0, 5'd7};
    cyc("mul_last", BYP ? 4'b0011 : 4'b0000, !BYP, 1);
    idex_src_addr = '0;
    cyc("mul_done", 4'b0000, 0, 0);

    // second multiply while busy
    clr(); idex_mul = 1'b1; idex_regwrite = 1'b1; idex_rd = 5'd8;
    cyc("mul2_issue", 4'b0000, 0, 0);
    idex_rd = 5'd9;
    cyc("struct1", 4'b0000, 1, 1);
    cyc("struct2", 4'b0000, 1, 1);
    cyc("struct3", 4'b0000, 1, 1);
    cyc("struct_issue", 4'b0000, 0, 0);
    idex_mul = 1'b0; idex_regwrite = 1'b0; idex_rd = 5'd0;
    cyc("mul2_busy", 4'b0000, 0, 1);
    id_src_use = 2'b01; id_src_addr = {5'd0, 5'd9};
    cyc("dep9", 4'b0000, 1, 1);
    rst_n = 1'b0;
    cyc("rst_mid", 4'b0000, 0, 0);
    rst_n = 1'b1;
    cyc("post_rst", 4'b0000, 0, 0);

    // multiply to r0 never enters busy
    clr(); idex_mul = 1'b1; idex_regwrite = 1'b1; idex_rd = 5'd0;
    cyc("mul_rd0", 4'b0000, 0, 0);
    clr();
    cyc("mul_rd0_idle", 4'b0000, 0, 0);

    // load-use and mwait together: a single stall cycle
    idex_mul = 1'b1; idex_regwrite = 1'b1; idex_rd = 5'd10;
    cyc("mul3_issue", 4'b0000, 0, 0);
    clr(); idex_memread = 1'b1; idex_regwrite = 1'b1; idex_rd = 5'd11;
    id_src_use = 2'b11; id_src_addr = {5'd11, 5'd10};
    cyc("luse_mwait", 4'b0000, 1, 1);
    clr();
    cyc("drain1", 4'b0000, 0, 1);
    cyc("drain2", 4'b0000, 0, 1);
    cyc("drain3", 4'b0000, 0, 0);

    // counter saturation
    idex_memread = 1'b1; idex_regwrite = 1'b1; idex_rd = 5'd5;
    id_src_use = 2'b01; id_src_addr = {5'd0, 5'd5};
    for (int i = 0; i < (1 << CNT_W) + 3; i++) cyc("sat", 4'b0000, 1, 0);
    clr();
    cyc("sat_hold", 4'b0000, 0, 0);

    @(negedge clk);
    cmp("end", "queue_left", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
